// File: rtl/hazard_stall_ctl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctl_pkg
// Shared definitions for the ID-stage hazard/stall controller:
//   - stall_reason_t : encoding reported on o_stallReason
//   - md_state_t     : states of the multiply/divide busy timer
//   - MD_LATENCY_DEFAULT : default busy length of the mul/div unit
//   - regMatch()     : register-compare helper that ignores $0 and unused
//                      source operands
// ---------------------------------------------------------------------------
package hazard_stall_ctl_pkg;

    typedef enum logic [1:0] {
        REASON_NONE     = 2'd0,
        REASON_LOAD_USE = 2'd1,
        REASON_BRANCH   = 2'd2,
        REASON_MULDIV   = 2'd3
    } stall_reason_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Cycles the mul/div unit stays busy after issue; legal range 2..63
    // because the busy counter is 6 bits wide.
    localparam int MD_LATENCY_DEFAULT = 32;

    // A producer register only hazards against a source operand the ID
    // instruction really reads, and $0 is hardwired so it never hazards.
    function automatic logic regMatch(input logic [4:0] producer,
                                      input logic [4:0] source,
                                      input logic       used);
        return used && (producer != 5'd0) && (producer == source);
    endfunction

endpackage

// File: rtl/hazard_stall_ctl_md_busy_timer.sv
// ---------------------------------------------------------------------------
// md_busy_timer
// Tracks occupancy of the multi-cycle multiply/divide unit.
// Ports:
//   i_clk    : clock, state updates on rising edge
//   i_rst    : asynchronous active-high reset, aborts any operation
//   i_start  : a mul/div instruction issues this cycle (already qualified
//              by valid and not-stalled in the parent)
//   o_busy   : unit occupied, high for MD_LATENCY cycles after issue edge
//   o_done   : one-cycle pulse during the final busy cycle
// ---------------------------------------------------------------------------
module md_busy_timer
    import hazard_stall_ctl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    output logic o_busy,
    output logic o_done
);

    // The counter is loaded with MD_LATENCY-1 and counts down to 0, so the
    // BUSY state lasts exactly MD_LATENCY cycles.
    localparam logic [5:0] LOAD_VALUE = 6'(MD_LATENCY - 1);

    md_state_t  r_state;
    md_state_t  w_stateNext;
    logic [5:0] r_count;
    logic [5:0] w_countNext;

    // State and counter registers. Reset drops straight back to IDLE so an
    // operation in flight is abandoned without ever producing o_done.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= MD_IDLE;
            r_count <= 6'd0;
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
        end
    end

    // Next-state and done logic. A start can only be accepted from IDLE:
    // while BUSY the parent stalls every mul/div instruction, so the first
    // cycle after the done pulse is where a waiting instruction issues.
    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_count;
        o_done      = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (i_start) begin
                    w_stateNext = MD_BUSY;
                    w_countNext = LOAD_VALUE;
                end
            end
            MD_BUSY: begin
                if (r_count == 6'd0) begin
                    o_done      = 1'b1;
                    w_stateNext = MD_IDLE;
                end else begin
                    w_countNext = r_count - 6'd1;
                end
            end
            default: begin
                w_stateNext = MD_IDLE;
                w_countNext = 6'd0;
            end
        endcase
    end

    assign o_busy = (r_state == MD_BUSY);

endmodule

// File: rtl/hazard_stall_ctl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctl
// ID-stage hazard detector for a 5-stage MIPS-style pipeline. Detects
// load-use, branch-operand and mul/div-busy hazards and stalls ID.
// Ports:
//   i_clk, i_rst        : clock / asynchronous active-high reset
//   i_instr             : instruction in ID
//   i_idValid           : ID holds a real instruction (0 = bubble)
//   i_regWrite          : ID instruction writes a register
//   i_regDest           : destination is rd (instr[15:11]) else rt
//   i_usesRs, i_usesRt  : ID instruction reads rs / rt
//   i_memRead           : ID instruction is a load
//   i_branch            : ID instruction resolves registers in ID
//   i_mulDivStart       : ID instruction is mult/multu/div/divu
//   i_hiLoAccess        : ID instruction is mfhi/mflo/mthi/mtlo
//   o_stall             : hold PC and IF/ID
//   o_bubbleEx          : inject NOP into ID/EX (same as o_stall)
//   o_stallReason       : 0 none, 1 load-use, 2 branch, 3 mul/div busy
//   o_mdBusy, o_mdDone  : mul/div unit occupied / final busy cycle pulse
// ---------------------------------------------------------------------------
module hazard_stall_ctl
    import hazard_stall_ctl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT
)(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_instr,
    input  logic        i_idValid,
    input  logic        i_regWrite,
    input  logic        i_regDest,
    input  logic        i_usesRs,
    input  logic        i_usesRt,
    input  logic        i_memRead,
    input  logic        i_branch,
    input  logic        i_mulDivStart,
    input  logic        i_hiLoAccess,
    output logic        o_stall,
    output logic        o_bubbleEx,
    output logic [1:0]  o_stallReason,
    output logic        o_mdBusy,
    output logic        o_mdDone
);

    logic [4:0]    w_rs;
    logic [4:0]    w_rt;
    logic [4:0]    w_idDst;
    logic          w_unusedInstrBits;

    logic [4:0]    r_exDst;
    logic          r_exLd;
    logic [4:0]    r_memDst;
    logic          r_memLd;

    logic          w_exMatch;
    logic          w_memMatch;
    logic          w_loadUseHaz;
    logic          w_branchHaz;
    logic          w_mdHaz;
    logic          w_stall;
    logic          w_mdStart;
    logic          w_mdBusy;
    logic          w_mdDone;
    stall_reason_t w_reason;

    assign w_rs              = i_instr[25:21];
    assign w_rt              = i_instr[20:16];
    assign w_unusedInstrBits = ^{i_instr[31:26], i_instr[10:0]};

    // Destination of the ID instruction; non-writers report $0, which the
    // compare helper treats as "never matches".
    assign w_idDst = i_regWrite ? (i_regDest ? i_instr[15:11] : i_instr[20:16])
                                : 5'd0;

    // Shadow copies of the EX and MEM destinations. A stalled or invalid ID
    // instruction enters EX as a bubble so it cannot hazard against itself.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_exDst  <= 5'd0;
            r_exLd   <= 1'b0;
            r_memDst <= 5'd0;
            r_memLd  <= 1'b0;
        end else begin
            r_memDst <= r_exDst;
            r_memLd  <= r_exLd;
            if (i_idValid && !w_stall) begin
                r_exDst <= w_idDst;
                r_exLd  <= i_memRead;
            end else begin
                r_exDst <= 5'd0;
                r_exLd  <= 1'b0;
            end
        end
    end

    // Hazard terms. Branches need operands in ID, so they wait on any EX
    // producer and additionally on a load still in MEM; that is why a branch
    // behind a load stalls twice (load-use first, then the MEM load).
    always_comb begin
        w_exMatch    = regMatch(r_exDst, w_rs, i_usesRs)
                     || regMatch(r_exDst, w_rt, i_usesRt);
        w_memMatch   = regMatch(r_memDst, w_rs, i_usesRs)
                     || regMatch(r_memDst, w_rt, i_usesRt);
        w_loadUseHaz = r_exLd && w_exMatch;
        w_branchHaz  = i_branch && (w_exMatch || (r_memLd && w_memMatch));
        w_mdHaz      = w_mdBusy && (i_mulDivStart || i_hiLoAccess);
        w_stall      = !i_rst && i_idValid
                     && (w_loadUseHaz || w_branchHaz || w_mdHaz);
    end

    // Reason code with mul/div taking precedence, then load-use, then branch.
    always_comb begin
        w_reason = REASON_NONE;
        if (w_stall) begin
            if (w_mdHaz) begin
                w_reason = REASON_MULDIV;
            end else if (w_loadUseHaz) begin
                w_reason = REASON_LOAD_USE;
            end else begin
                w_reason = REASON_BRANCH;
            end
        end
    end

    // A mul/div held back by any hazard must not start the unit.
    assign w_mdStart = i_idValid && i_mulDivStart && !w_stall;

    md_busy_timer #(
        .MD_LATENCY (MD_LATENCY)
    ) u_mdBusyTimer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_mdStart),
        .o_busy  (w_mdBusy),
        .o_done  (w_mdDone)
    );

    assign o_stall       = w_stall;
    assign o_bubbleEx    = w_stall;
    assign o_stallReason = w_reason;
    assign o_mdBusy      = w_mdBusy;
    assign o_mdDone      = w_mdDone;

endmodule

// File: doc/hazard_stall_ctl.md
HAZARD_STALL_CTL -- requirements
Module: hazard_stall_ctl

Interface
REQ-001 Parameter MD_LATENCY, default 32, meaning cycles the multiply/divide unit stays busy after issue (legal 2..63).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 Instr  input  32  instruction currently in ID.
REQ-005 ID_Valid  input  1  ID holds a real instruction; 0 means bubble, with no hazard checks.
REQ-006 RegWrite  input  1  ID instruction writes a register.
REQ-007 RegDest  input  1  destination is Instr[15:11], else Instr[20:16].
REQ-008 UsesRs / UsesRt  input  1 each  ID instruction reads Instr[25:21] / Instr[20:16].
REQ-009 MemRead  input  1  ID instruction is a load.
REQ-010 Branch  input  1  ID instruction compares registers or jumps through a register in ID.
REQ-011 MulDivStart  input  1  ID instruction is mult/multu/div/divu.
REQ-012 HiLoAccess  input  1  ID instruction is mfhi/mflo/mthi/mtlo.
REQ-013 Stall  output  1  hold PC and IF/ID.
REQ-014 Bubble_EX  output  1  inject NOP into ID/EX; always equals Stall.
REQ-015 StallReason  output  2  0 none, 1 load-use, 2 branch operand, 3 mul/div busy.
REQ-016 MD_Busy  output  1  mul/div unit occupied.
REQ-017 MD_Done  output  1  one-cycle pulse in the final busy cycle.

Function
REQ-018 Definitions: IDdst = RegWrite ? (RegDest ? Instr[15:11] : Instr[20:16]) : 0; rs/rt count only when UsesRs/UsesRt; register 0 never matches.
REQ-019 Tracking registers: EX_dst, EX_ld, MEM_dst, MEM_ld; each cycle MEM_* <= EX_*.
REQ-020 EX_* <= {IDdst, MemRead} when ID_Valid and not Stall, else {0,0} (bubble).
REQ-021 Load-use hazard: EX_ld and EX_dst equals a used rs/rt.
REQ-022 Branch hazard: Branch and (EX_dst matches a used rs/rt, or MEM_ld and MEM_dst matches a used rs/rt).
REQ-023 Mul/div hazard: MD_Busy and (MulDivStart or HiLoAccess).
REQ-024 Stall = ID_Valid and (any hazard); combinational in the same cycle, with no registered delay.
REQ-025 StallReason priority when simultaneous: mul/div (3) > load-use (1) > branch (2).
REQ-026 Load-use stalls last exactly 1 cycle.
REQ-027 Branch stalls last 1 cycle behind an ALU producer in EX, and 2 cycles behind a load in EX, because the second cycle sees the load in MEM.
REQ-028 Mul/div FSM states: IDLE, BUSY.
REQ-029 IDLE -> BUSY when ID_Valid and MulDivStart and not Stall; the counter loads MD_LATENCY-1.
REQ-030 In BUSY the counter decrements each cycle.
REQ-031 In BUSY, at count 0: MD_Done=1 and the next state is IDLE.
REQ-032 MD_Busy=1 exactly for the MD_LATENCY cycles following the issue edge.
REQ-033 A mul/div or HI/LO access waiting in ID issues in the first cycle after MD_Done, with no stall that cycle.
REQ-034 Back-to-back issue: a MulDivStart in the cycle after MD_Done re-enters BUSY with no idle gap.
REQ-035 A MulDivStart that is itself stalled by load-use does not start the unit.

Reset
REQ-036 While RESET=1: EX_dst, MEM_dst=0; EX_ld, MEM_ld=0; FSM=IDLE; counter=0.
REQ-037 While RESET=1: Stall, Bubble_EX, MD_Busy, MD_Done=0; StallReason=0.
REQ-038 Reset asserted mid-BUSY aborts the operation immediately, with no MD_Done pulse.

Structure
REQ-039 The shared package holds StallReason codes, FSM state encodings and the MD_LATENCY default.
REQ-040 One sub-module, md_busy_timer, holds the mul/div FSM and counter; hazard comparison stays in the top level.

Verification
REQ-041 lw $5 followed by add $6,$5,$7 -> Stall=1 for 1 cycle with StallReason=1; then add issues and EX_dst=6 the next cycle.
REQ-042 add $3,$1,$2 followed by beq $3,$4 -> 1 stall cycle with StallReason=2; lw $3 followed by beq $3,$0 -> 2 stall cycles.
REQ-043 mult with MD_LATENCY=32 followed by mflo -> MD_Busy high 32 cycles; mflo stalled 32 cycles with StallReason=3; MD_Done pulses once; mflo issues the next cycle.
REQ-044 lw $0 followed by add using $0, and ID_Valid=0 with matching registers -> no stall.
REQ-045 RESET asserted in cycle 10 of a BUSY period -> all outputs 0 asynchronously; no MD_Done pulse; a new mult after release runs the full 32 cycles.
REQ-046 Simultaneous lw-hazard and mul/div-busy on an mflo using the load register -> StallReason=3 until MD_Done; Stall drops once both hazards clear.
